// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: handshake and datapath-control bundle between sequencer and datapath
interface multicycle_controller_if #(parameter int COUNT_WIDTH = 16);
  logic                   start;
  logic [31:0]            instruction;
  logic                   memReady;
  logic                   zero;
  logic                   pcWrite;
  logic                   irWrite;
  logic [1:0]             ALUOp;
  logic                   ALUSrc;
  logic                   regWrite;
  logic                   memoryToRegister;
  logic                   memoryRead;
  logic                   memoryWrite;
  logic                   branchTaken;
  logic                   illegal;
  logic                   done;
  logic                   fault;
  logic [2:0]             state;
  logic [COUNT_WIDTH-1:0] retired;
  modport master(
    input  start, instruction, memReady, zero,
    output pcWrite, irWrite, ALUOp, ALUSrc, regWrite, memoryToRegister, memoryRead,
           memoryWrite, branchTaken, illegal, done, fault, state, retired
  );
  modport slave(
    output start, instruction, memReady, zero,
    input  pcWrite, irWrite, ALUOp, ALUSrc, regWrite, memoryToRegister, memoryRead,
           memoryWrite, branchTaken, illegal, done, fault, state, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer with memory timeout and retire counter
module multicycle_controller #(
  parameter int TIMEOUT     = 15,
  parameter int COUNT_WIDTH = 16
) (
  input logic clock,
  input logic reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ} cls_t;
  state_t                 r_state, w_next;
  cls_t                   r_cls, w_dec;
  logic [7:0]             r_wait;
  logic                   r_fault;
  logic [COUNT_WIDTH-1:0] r_retired;
  logic [6:0]             w_op;
  logic                   w_legal, w_ecall, w_tmo, w_retire, w_en;
  logic                   w_f, w_e, w_m, w_w, w_alu, w_beq, w_lw, w_sw, w_take;
  always_comb begin
    w_op    = bus.instruction[6:0];
    w_dec   = w_op == 7'b0110011 ? C_R  : w_op == 7'b0010011 ? C_I :
              w_op == 7'b0000011 ? C_LW : w_op == 7'b0100011 ? C_SW : C_BEQ;
    w_legal = w_op == 7'b0110011 || w_op == 7'b0010011 || w_op == 7'b0000011 ||
              w_op == 7'b0100011 || (w_op == 7'b1100011 && bus.instruction[14:12] == 3'b000);
    w_ecall = bus.instruction == 32'h0000_0073;
    w_tmo   = !bus.memReady && r_wait == 8'(TIMEOUT - 1);
    w_alu   = r_cls == C_R || r_cls == C_I;
    w_beq   = r_cls == C_BEQ;
    w_lw    = r_cls == C_LW;
    w_sw    = r_cls == C_SW;
    w_next  = IDLE;
    case (r_state)
      IDLE:      w_next = bus.start ? FETCH : IDLE;
      FETCH:     w_next = bus.memReady ? DECODE : w_tmo ? HALT : FETCH;
      DECODE:    w_next = w_legal ? EXECUTE : w_ecall ? HALT : FETCH;
      EXECUTE:   w_next = w_alu ? WRITEBACK : w_beq ? FETCH : MEMORY;
      MEMORY:    w_next = bus.memReady ? (w_lw ? WRITEBACK : FETCH) : w_tmo ? HALT : MEMORY;
      WRITEBACK: w_next = FETCH;
      HALT:      w_next = HALT;
      default:   w_next = IDLE;
    endcase
    w_retire = r_state == WRITEBACK || (r_state == MEMORY && w_sw && bus.memReady) ||
               (r_state == EXECUTE && w_beq);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cls     <= C_R;
      r_wait    <= '0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_cls <= w_dec;
      r_wait <= ((r_state == FETCH || r_state == MEMORY) && w_next == r_state) ? r_wait + 8'd1 : 8'd0;
      if ((r_state == FETCH || r_state == MEMORY) && w_tmo) r_fault <= 1'b1;
      if (w_retire && !(&r_retired)) r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end
  // controls are masked while reset is held so nothing writes during the abort cycle
  assign w_en   = !reset;
  assign w_f    = r_state == FETCH;
  assign w_e    = r_state == EXECUTE;
  assign w_m    = r_state == MEMORY;
  assign w_w    = r_state == WRITEBACK;
  assign w_take = w_e && w_beq && bus.zero;
  assign bus.irWrite          = w_en && w_f && bus.memReady;
  assign bus.pcWrite          = w_en && ((w_f && bus.memReady) || w_take);
  assign bus.branchTaken      = w_en && w_take;
  assign bus.ALUOp            = !w_en || !w_e ? 2'b00 : w_alu ? 2'b10 : w_beq ? 2'b01 : 2'b00;
  assign bus.ALUSrc           = w_en && w_e && (r_cls == C_I || w_lw || w_sw);
  assign bus.regWrite         = w_en && w_w;
  assign bus.memoryToRegister = w_en && w_w && w_lw;
  assign bus.memoryRead       = w_en && (w_f || (w_m && w_lw));
  assign bus.memoryWrite      = w_en && w_m && w_sw;
  assign bus.illegal          = w_en && r_state == DECODE && !w_legal && !w_ecall;
  assign bus.done             = w_en && r_state == HALT;
  assign bus.fault            = r_fault;
  assign bus.state            = r_state;
  assign bus.retired          = r_retired;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control sequencer for the RISC-V datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath control lines (ALUOp, ALUSrc, regWrite, memoryToRegister, memoryRead, memoryWrite) plus PC and IR write enables. It waits on a memory ready handshake, with a timeout, and counts retired instructions. It replaces the single-cycle opcode decoder when the datapath runs in multi-cycle mode.

## Interface
- TIMEOUT, 15: maximum cycles spent waiting for memReady in one memory access before faulting (legal range 1..255).
- COUNT_WIDTH, 16: width of the retired-instruction counter.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  begin execution; sampled only in IDLE.
- instruction  in  32  IR output; opcode = instruction[6:0], funct3 = instruction[14:12].
- memReady  in  1  memory acknowledges the current read/write.
- zero  in  1  ALU zero flag; used for beq.
- pcWrite  out  1  load PC (PC+4 in FETCH, branch target in EXECUTE).
- irWrite  out  1  load instruction register.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- ALUSrc  out  1  1 selects immediate as ALU operand B.
- regWrite, memoryToRegister, memoryRead, memoryWrite  out  1 each  datapath controls.
- branchTaken  out  1  one-cycle pulse when beq is taken.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- done  out  1  high in HALT.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  current state encoding, for debug.
- retired  out  COUNT_WIDTH  retired-instruction count; saturates at all-ones.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Encoding 7 is unreachable and recovers to IDLE.
- IDLE: all controls 0. If start=1, go to FETCH. start is ignored in every other state.
- FETCH: memoryRead=1.
  - If memReady=1: irWrite=1 and pcWrite=1 (Mealy, same cycle), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: uses the held IR opcode, which is latched internally as the class register.
  - Opcode 0110011 (R), 0010011 (I-ALU), 0000011 (lw), 0100011 (sw), or 1100011 with funct3=000 (beq): go to EXECUTE.
  - instruction == 32'h00000073 (ecall): go to HALT.
  - Anything else: illegal=1 pulse, go to FETCH; not counted as retired.
- EXECUTE:
  - R: ALUOp=10, ALUSrc=0, go to WRITEBACK.
  - I-ALU: ALUOp=10, ALUSrc=1, go to WRITEBACK.
  - lw/sw: ALUOp=00, ALUSrc=1, go to MEMORY.
  - beq: ALUOp=01, ALUSrc=0. If zero=1, pcWrite=1 and branchTaken=1 in this cycle. Go to FETCH.
- MEMORY: lw drives memoryRead=1; sw drives memoryWrite=1. Held until memReady=1.
  - lw then goes to WRITEBACK.
  - sw then goes to FETCH.
- WRITEBACK: regWrite=1 for exactly one cycle; memoryToRegister=1 only for lw. Then go to FETCH.
- Retirement: retired increments by 1 on leaving WRITEBACK, on sw leaving MEMORY, and on beq leaving EXECUTE. It holds at all-ones once saturated.
- Timeout:
  - waitCount clears on entry to FETCH or MEMORY and increments each cycle while memReady=0.
  - If memReady=0 and waitCount == TIMEOUT-1: next state is HALT and fault is set; no enables are asserted.
  - memReady arriving on the TIMEOUT-th wait cycle is still accepted.
- HALT: done=1, all other controls 0. The block stays in HALT until reset.

## Timing
- Reset values: state=IDLE; retired=0; waitCount=0; fault=0; every output 0.
- Reset mid-instruction aborts at the next edge. No write enables are asserted in the reset cycle.
- Latency, start-accepted to next FETCH, with memReady high on the first wait cycle:
  - R/I: 4 cycles (F, D, E, W).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each memReady delay cycle adds 1.
- pcWrite, irWrite, regWrite, branchTaken and illegal are single-cycle pulses per instruction.
- memoryRead and memoryWrite stay asserted, level-held, for the full wait.
- Outputs are combinational from state, latched class, memReady and zero. No output registers.

## Test plan
- Reset mid-op: reset during MEMORY of lw -> next cycle state=0, all outputs 0, retired=0, fault=0.
- R-type: start=1, instruction=32'h002081B3 (add x3,x1,x2), memReady=1 -> states 1,2,3,5,1; regWrite for one cycle with memoryToRegister=0; retired=1 after 4 cycles.
- lw with 3-cycle memory wait: instruction=32'h0000A183, memReady low 3 cycles in MEMORY -> memoryRead held 4 cycles, then WRITEBACK with memoryToRegister=1; retired increments.
- beq taken/untaken: instruction=32'h00208463 with zero=1 -> pcWrite and branchTaken in EXECUTE; with zero=0 -> neither asserted; both cases retire after 3 cycles.
- Timeout: TIMEOUT=4, memReady held 0 in FETCH -> HALT after 4 FETCH cycles, fault=1, done=1, irWrite never asserted. A separate run with memReady on the 4th cycle proceeds to DECODE.
- Illegal and ecall: instruction=32'h0000007F -> illegal pulse in DECODE, back to FETCH, retired unchanged. instruction=32'h00000073 -> done=1, start ignored until reset.
